ram_arbiter: RTL and testbench

Sequential arbiter that shares the single SDRAM-backed `sram` port between three requesters: the file loader (`ioctl` download), the video DMA (`k580vt57` channel 2 reads for `k580vg75`), and the CPU (including `ppa2` extended-ROM reads). It replaces the combinational address/data mux in front of `sram` with registered request/acknowledge handshakes, a fixed access window and a CPU anti-starvation rule. It sits in the top level between the requesters and `sram`.

---
 rtl/ram_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares the single SDRAM-backed memory port between the file loader,
// the video DMA and the CPU. Each access is granted in IDLE, holds the
// memory strobe for ACC_CYCLES clocks in ACC, and finishes with a
// one-cycle acknowledge in ACK. Priority is loader > DMA > CPU. The CPU
// beats the DMA after it has lost to the DMA twice in a row.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   ld_req/addr/din       loader write request (held until ld_ack)
//   ld_ack                one-cycle loader completion pulse
//   dma_req/addr          DMA read request (held until dma_ack)
//   dma_ack, dma_dout     DMA completion pulse and read data register
//   cpu_req/we/addr/din   CPU request (held until cpu_ack)
//   cpu_ack, cpu_dout     CPU completion pulse and read data register
//   mem_addr/din/we/rd    registered memory-side command
//   mem_dout              memory read data
//   grant                 current owner: 0 none, 1 loader, 2 DMA, 3 CPU
//   busy                  high whenever the arbiter is not in IDLE
module ram_arbiter #(
  parameter int AW         = 25,
  parameter int ACC_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_din,
  output logic          ld_ack,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  output logic          dma_ack,
  output logic [7:0]    dma_dout,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_ack,
  output logic [7:0]    cpu_dout,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic [7:0]    mem_dout,
  output logic [1:0]    grant,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_LD   = 2'd1;
  localparam logic [1:0] G_DMA  = 2'd2;
  localparam logic [1:0] G_CPU  = 2'd3;

  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]      mem_din_q, mem_din_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_rd_q, mem_rd_d;
  logic            ld_ack_q, ld_ack_d;
  logic            dma_ack_q, dma_ack_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic [7:0]      dma_dout_q, dma_dout_d;
  logic [7:0]      cpu_dout_q, cpu_dout_d;
  logic [1:0]      cpu_skip_q, cpu_skip_d;
  logic [1:0]      winner;

  // Winner selection. The CPU only overtakes the DMA once it has been
  // passed over twice; the loader always wins.
  always_comb begin
    winner = G_NONE;
    if (ld_req) begin
      winner = G_LD;
    end else if (dma_req && !(cpu_req && (cpu_skip_q == 2'd2))) begin
      winner = G_DMA;
    end else if (cpu_req) begin
      winner = G_CPU;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = mem_we_q;
    mem_rd_d   = mem_rd_q;
    ld_ack_d   = 1'b0;
    dma_ack_d  = 1'b0;
    cpu_ack_d  = 1'b0;
    dma_dout_d = dma_dout_q;
    cpu_dout_d = cpu_dout_q;
    cpu_skip_d = cpu_skip_q;

    unique case (state_q)
      S_IDLE: begin
        grant_d  = G_NONE;
        busy_d   = 1'b0;
        mem_we_d = 1'b0;
        mem_rd_d = 1'b0;
        unique case (winner)
          G_LD: begin
            mem_addr_d = ld_addr;
            mem_din_d  = ld_din;
            mem_we_d   = 1'b1;
          end
          G_DMA: begin
            mem_addr_d = dma_addr;
            mem_rd_d   = 1'b1;
          end
          G_CPU: begin
            mem_addr_d = cpu_addr;
            mem_din_d  = cpu_din;
            mem_we_d   = cpu_we;
            mem_rd_d   = ~cpu_we;
          end
          default: ;
        endcase
        if (winner != G_NONE) begin
          grant_d = winner;
          busy_d  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = S_ACC;
          // A loader grant with the CPU waiting leaves the skip count alone.
          if ((winner == G_DMA) && cpu_req) begin
            cpu_skip_d = (cpu_skip_q == 2'd2) ? 2'd2 : cpu_skip_q + 2'd1;
          end else if ((winner == G_CPU) || !cpu_req) begin
            cpu_skip_d = 2'd0;
          end
        end
      end

      S_ACC: begin
        if (cnt_q == 4'd0) begin
          mem_we_d = 1'b0;
          mem_rd_d = 1'b0;
          state_d  = S_ACK;
          if (mem_rd_q) begin
            if (grant_q == G_DMA) dma_dout_d = mem_dout;
            if (grant_q == G_CPU) cpu_dout_d = mem_dout;
          end
          ld_ack_d  = (grant_q == G_LD);
          dma_ack_d = (grant_q == G_DMA);
          cpu_ack_d = (grant_q == G_CPU);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_ACK: begin
        // grant stays visible through ACK and drops for the IDLE cycle.
        grant_d = G_NONE;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        grant_d  = G_NONE;
        busy_d   = 1'b0;
        mem_we_d = 1'b0;
        mem_rd_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      grant_q    <= G_NONE;
      busy_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= 8'd0;
      mem_we_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      ld_ack_q   <= 1'b0;
      dma_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      dma_dout_q <= 8'd0;
      cpu_dout_q <= 8'd0;
      cpu_skip_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      mem_rd_q   <= mem_rd_d;
      ld_ack_q   <= ld_ack_d;
      dma_ack_q  <= dma_ack_d;
      cpu_ack_q  <= cpu_ack_d;
      dma_dout_q <= dma_dout_d;
      cpu_dout_q <= cpu_dout_d;
      cpu_skip_q <= cpu_skip_d;
    end
  end

  assign ld_ack   = ld_ack_q;
  assign dma_ack  = dma_ack_q;
  assign cpu_ack  = cpu_ack_q;
  assign dma_dout = dma_dout_q;
  assign cpu_dout = cpu_dout_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign mem_rd   = mem_rd_q;
  assign grant    = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Self-checking bench for ram_arbiter. The main instance uses ACC_CYCLES=4
// with a small memory model; a second instance uses ACC_CYCLES=2 with a
// fixed read pattern. Expected acknowledges are queued when requests are
// driven and compared (owner, timing, strobe length, read data) when the
// acknowledge appears.
module tb_ram_arbiter;

  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_req, dma_req, cpu_req, cpu_we;
  logic [AW-1:0] ld_addr, dma_addr, cpu_addr;
  logic [7:0]    ld_din, cpu_din;
  logic          ld_ack, dma_ack, cpu_ack;
  logic [7:0]    dma_dout, cpu_dout;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din, mem_dout;
  logic          mem_we, mem_rd, busy;
  logic [1:0]    grant;

  logic          ld_req_b, dma_req_b, cpu_req_b, cpu_we_b;
  logic [AW-1:0] ld_addr_b, dma_addr_b, cpu_addr_b;
  logic [7:0]    ld_din_b, cpu_din_b;
  logic          ld_ack_b, dma_ack_b, cpu_ack_b;
  logic [7:0]    dma_dout_b, cpu_dout_b;
  logic [AW-1:0] mem_addr_b;
  logic [7:0]    mem_din_b, mem_dout_b;
  logic          mem_we_b, mem_rd_b, busy_b;
  logic [1:0]    grant_b;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .ACC_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_din(ld_din), .ld_ack(ld_ack),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_dout(dma_dout),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_dout(mem_dout), .grant(grant), .busy(busy)
  );

  ram_arbiter #(.AW(AW), .ACC_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset),
    .ld_req(ld_req_b), .ld_addr(ld_addr_b), .ld_din(ld_din_b), .ld_ack(ld_ack_b),
    .dma_req(dma_req_b), .dma_addr(dma_addr_b), .dma_ack(dma_ack_b), .dma_dout(dma_dout_b),
    .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_din(cpu_din_b),
    .cpu_ack(cpu_ack_b), .cpu_dout(cpu_dout_b),
    .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_we(mem_we_b), .mem_rd(mem_rd_b),
    .mem_dout(mem_dout_b), .grant(grant_b), .busy(busy_b)
  );

  // Memory model for the main instance: 4K bytes, low address bits only.
  logic [7:0] ram [0:4095];
  assign mem_dout = ram[mem_addr[11:0]];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[11:0]] <= mem_din;
  end

  // Second instance only ever reads 0x3C from address 0x42.
  assign mem_dout_b = (mem_rd_b && (mem_addr_b == 25'h42)) ? 8'h3C : 8'h00;

  typedef struct {
    logic [1:0] who;
    bit         rd;
    logic [7:0] dout;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [1:0]    who;
    bit            we;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic [7:0]    dout;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[8];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         we_cnt = 0;
  int         rd_cnt = 0;
  bit         ack_now;
  bit         hold_ld = 0, hold_dma = 0, hold_cpu = 0;
  logic [7:0] last_dma = 8'h00;
  logic [7:0] last_cpu = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushExp(input logic [1:0] who, input bit rd, input logic [7:0] dout, input int at);
    exp_t e;
    e.who = who; e.rd = rd; e.dout = dout; e.cyc = at;
    sb.push_back(e);
  endtask

  // Advance one clock, sampling on the falling edge; scoreboard any ack
  // and release requests whose ack has been seen unless they are held.
  task automatic stepCycle();
    exp_t e;
    logic [2:0] ack_vec;
    @(negedge clk);
    cyc++;
    ack_now = 1'b0;
    if (reset) begin
      we_cnt = 0; rd_cnt = 0;
      last_dma = 8'h00; last_cpu = 8'h00;
    end else begin
      if (mem_we) we_cnt++;
      if (mem_rd) rd_cnt++;
      checkOutput("busy_vs_grant", 32'(busy), 32'(grant != 2'd0));
      ack_vec = {ld_ack, dma_ack, cpu_ack};
      if (ack_vec != 3'b000) begin
        ack_now = 1'b1;
        if (sb.size() == 0) begin
          checkOutput("unexpected_ack", 32'(ack_vec), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("grant", 32'(grant), 32'(e.who));
          checkOutput("ack_vector", 32'(ack_vec), 32'(3'b100 >> (e.who - 2'd1)));
          checkOutput("ack_cycle", cyc, e.cyc);
          checkOutput("we_cycles", we_cnt, e.rd ? 0 : 4);
          checkOutput("rd_cycles", rd_cnt, e.rd ? 4 : 0);
          if (e.rd && e.who == 2'd2) last_dma = e.dout;
          if (e.rd && e.who == 2'd3) last_cpu = e.dout;
          checkOutput("dma_dout", 32'(dma_dout), 32'(last_dma));
          checkOutput("cpu_dout", 32'(cpu_dout), 32'(last_cpu));
        end
        we_cnt = 0; rd_cnt = 0;
        if (ld_ack && !hold_ld) ld_req = 1'b0;
        if (dma_ack && !hold_dma) dma_req = 1'b0;
        if (cpu_ack && !hold_cpu) cpu_req = 1'b0;
      end
    end
  endtask

  task automatic waitAcks(input int n, input int budget);
    int seen = 0;
    for (int k = 0; k < budget && seen < n; k++) begin
      stepCycle();
      if (ack_now) seen++;
    end
    checkOutput("acks_received", seen, n);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) stepCycle();
  endtask

  // One isolated access from an idle arbiter; ack due 5 cycles later.
  task automatic applyStimulus(input vec_t v);
    stepCycle();
    unique case (v.who)
      2'd1: begin ld_addr = v.addr; ld_din = v.din; ld_req = 1'b1; end
      2'd2: begin dma_addr = v.addr; dma_req = 1'b1; end
      default: begin
        cpu_addr = v.addr; cpu_din = v.din; cpu_we = v.we; cpu_req = 1'b1;
      end
    endcase
    pushExp(v.who, (v.who == 2'd2) || (v.who == 2'd3 && !v.we), v.dout, cyc + 5);
    waitAcks(1, 20);
  endtask

  initial begin
    int c;
    int ack_at;
    int rd_b;
    bit saw_ack;

    vecs[0] = '{2'd3, 1'b1, 25'h01234, 8'hA5, 8'h00};
    vecs[1] = '{2'd3, 1'b0, 25'h01234, 8'h00, 8'hA5};
    vecs[2] = '{2'd1, 1'b1, 25'h00100, 8'h5A, 8'h00};
    vecs[3] = '{2'd2, 1'b0, 25'h00100, 8'h00, 8'h5A};
    vecs[4] = '{2'd3, 1'b1, 25'h00FFF, 8'hFF, 8'h00};
    vecs[5] = '{2'd2, 1'b0, 25'h00FFF, 8'h00, 8'hFF};
    vecs[6] = '{2'd3, 1'b0, 25'h00100, 8'h00, 8'h5A};
    vecs[7] = '{2'd2, 1'b0, 25'h01234, 8'h00, 8'hA5};

    reset = 1'b1;
    ld_req = 0; dma_req = 0; cpu_req = 0; cpu_we = 0;
    ld_addr = '0; dma_addr = '0; cpu_addr = '0; ld_din = 0; cpu_din = 0;
    ld_req_b = 0; dma_req_b = 0; cpu_req_b = 0; cpu_we_b = 0;
    ld_addr_b = '0; dma_addr_b = '0; cpu_addr_b = '0; ld_din_b = 0; cpu_din_b = 0;

    idleCycles(3);
    checkOutput("rst_grant", 32'(grant), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_mem_we", 32'(mem_we), 0);
    checkOutput("rst_mem_rd", 32'(mem_rd), 0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 0);
    checkOutput("rst_mem_din", 32'(mem_din), 0);
    checkOutput("rst_acks", 32'({ld_ack, dma_ack, cpu_ack}), 0);
    checkOutput("rst_douts", 32'({dma_dout, cpu_dout}), 0);
    reset = 1'b0;

    // Isolated accesses from the vector table.
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
    idleCycles(2);

    // All three requesters rise together: loader, DMA, CPU, 6 cycles apart.
    stepCycle();
    c = cyc;
    ld_addr = 25'h00200; ld_din = 8'h77; ld_req = 1'b1;
    dma_addr = 25'h00200; dma_req = 1'b1;
    cpu_addr = 25'h00200; cpu_we = 1'b0; cpu_req = 1'b1;
    pushExp(2'd1, 1'b0, 8'h00, c + 5);
    pushExp(2'd2, 1'b1, 8'h77, c + 11);
    pushExp(2'd3, 1'b1, 8'h77, c + 17);
    waitAcks(3, 40);
    idleCycles(4);

    // DMA always requesting with a CPU read pending: 2,2,3,2,2,3.
    stepCycle();
    c = cyc;
    hold_dma = 1; hold_cpu = 1;
    dma_addr = 25'h00100; dma_req = 1'b1;
    cpu_addr = 25'h01234; cpu_we = 1'b0; cpu_req = 1'b1;
    pushExp(2'd2, 1'b1, 8'h5A, c + 5);
    pushExp(2'd2, 1'b1, 8'h5A, c + 11);
    pushExp(2'd3, 1'b1, 8'hA5, c + 17);
    pushExp(2'd2, 1'b1, 8'h5A, c + 23);
    pushExp(2'd2, 1'b1, 8'h5A, c + 29);
    pushExp(2'd3, 1'b1, 8'hA5, c + 35);
    waitAcks(6, 60);
    dma_req = 1'b0; cpu_req = 1'b0; hold_dma = 0; hold_cpu = 0;
    idleCycles(6);

    // Two DMA wins arm the CPU; loader grants in between must not disarm it.
    stepCycle();
    c = cyc;
    hold_dma = 1; hold_cpu = 1;
    dma_addr = 25'h00100; dma_req = 1'b1;
    cpu_addr = 25'h01234; cpu_we = 1'b0; cpu_req = 1'b1;
    pushExp(2'd2, 1'b1, 8'h5A, c + 5);
    pushExp(2'd2, 1'b1, 8'h5A, c + 11);
    pushExp(2'd1, 1'b0, 8'h00, c + 17);
    pushExp(2'd1, 1'b0, 8'h00, c + 23);
    pushExp(2'd3, 1'b1, 8'hA5, c + 29);
    waitAcks(2, 20);
    ld_addr = 25'h00400; ld_din = 8'h99; ld_req = 1'b1; hold_ld = 1;
    waitAcks(1, 10);
    hold_ld = 0;
    waitAcks(1, 10);
    hold_cpu = 0;
    waitAcks(1, 10);
    dma_req = 1'b0; hold_dma = 0;
    idleCycles(6);

    // Reset during the second ACC cycle of a CPU write.
    stepCycle();
    cpu_addr = 25'h00300; cpu_din = 8'h11; cpu_we = 1'b1; cpu_req = 1'b1;
    idleCycles(2);
    checkOutput("pre_rst_mem_we", 32'(mem_we), 1);
    reset = 1'b1;
    stepCycle();
    checkOutput("abort_mem_we", 32'(mem_we), 0);
    checkOutput("abort_grant", 32'(grant), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_cpu_dout", 32'(cpu_dout), 0);
    checkOutput("abort_mem_addr", 32'(mem_addr), 0);
    cpu_req = 1'b0;
    stepCycle();
    reset = 1'b0;
    saw_ack = 0;
    for (int k = 0; k < 8; k++) begin
      stepCycle();
      if (cpu_ack) saw_ack = 1;
    end
    checkOutput("no_ack_after_abort", 32'(saw_ack), 0);
    applyStimulus('{2'd3, 1'b1, 25'h00300, 8'h22, 8'h00});
    applyStimulus('{2'd3, 1'b0, 25'h00300, 8'h00, 8'h22});
    idleCycles(2);

    // ACC_CYCLES=2 instance: DMA read of 0x42.
    stepCycle();
    c = cyc;
    dma_addr_b = 25'h42; dma_req_b = 1'b1;
    ack_at = -1; rd_b = 0;
    for (int k = 0; k < 12; k++) begin
      stepCycle();
      if (mem_rd_b) rd_b++;
      if (dma_ack_b && ack_at < 0) begin
        ack_at = cyc;
        dma_req_b = 1'b0;
        checkOutput("b_grant", 32'(grant_b), 2);
      end
    end
    checkOutput("b_rd_cycles", rd_b, 2);
    checkOutput("b_ack_cycle", ack_at, c + 3);
    checkOutput("b_dma_dout", 32'(dma_dout_b), 32'h3C);
    checkOutput("b_cpu_ack", 32'(cpu_ack_b), 0);

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
